program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 185 ++++++++++++++++++
 tb/tb_program_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Buffers a program from a host, then streams it to a processor one word per
//   cycle, holds the processor's run request for RUN_CYCLES cycles and pulses
//   done. An abort returns the loader to an empty IDLE state at the next edge.
//
//   state  | meaning
//   -------+------------------------------------------------------------------
//   IDLE   | accepting host words until in_last or the buffer fills
//   LOAD   | one write strobe per cycle, oldest buffered word first
//   RUN    | start held high for RUN_CYCLES cycles
//   FINISH | one-cycle done pulse; buffer count and pointers already cleared
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : host handshake for in_word / in_last
//   in_word, in_last     : program word and end-of-program marker
//   abort                : cancel current program at any state
//   write, program_in    : registered write strobe and word to the processor
//   start                : run request to the processor
//   busy, done           : not-IDLE indicator, end-of-run pulse
//   count                : words currently buffered
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int WORD_W     = 23,
    parameter int DEPTH      = 16,
    parameter int RUN_CYCLES = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W-1:0]        in_word,
    input  logic                     in_last,
    input  logic                     abort,
    output logic                     write,
    output logic [WORD_W-1:0]        program_in,
    output logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RUN_W = $clog2(RUN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     remain_q, remain_d;
    logic [RUN_W-1:0]     run_cnt_q, run_cnt_d;
    logic                 write_q, write_d;
    logic [WORD_W-1:0]    program_in_q, program_in_d;
    logic                 start_q, start_d;
    logic                 done_q, done_d;
    logic [WORD_W-1:0]    mem_q [DEPTH];
    logic                 accept;

    assign in_ready   = (state_q == ST_IDLE) && (count_q < CNT_W'(DEPTH));
    assign accept     = in_valid && in_ready && !abort;
    assign busy       = (state_q != ST_IDLE);
    assign count      = count_q;
    assign write      = write_q;
    assign program_in = program_in_q;
    assign start      = start_q;
    assign done       = done_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        remain_d     = remain_q;
        run_cnt_d    = run_cnt_q;
        write_d      = 1'b0;
        program_in_d = '0;
        start_d      = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                    if (in_last || (count_q == CNT_W'(DEPTH - 1))) begin
                        // First strobe is launched on the closing edge so it
                        // appears in the first LOAD cycle. With an empty
                        // buffer the oldest word is the one arriving now.
                        state_d      = ST_LOAD;
                        write_d      = 1'b1;
                        program_in_d = (count_q == '0) ? in_word : mem_q[rd_ptr_q];
                        rd_ptr_d     = rd_ptr_q + 1'b1;
                        remain_d     = count_q;
                    end
                end
            end
            ST_LOAD: begin
                if (remain_q != '0) begin
                    write_d      = 1'b1;
                    program_in_d = mem_q[rd_ptr_q];
                    rd_ptr_d     = rd_ptr_q + 1'b1;
                    remain_d     = remain_q - 1'b1;
                end else begin
                    state_d   = ST_RUN;
                    start_d   = 1'b1;
                    run_cnt_d = RUN_W'(RUN_CYCLES - 1);
                end
            end
            ST_RUN: begin
                if (run_cnt_q != '0) begin
                    start_d   = 1'b1;
                    run_cnt_d = run_cnt_q - 1'b1;
                end else begin
                    state_d  = ST_FINISH;
                    done_d   = 1'b1;
                    count_d  = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d      = ST_IDLE;
            count_d      = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            remain_d     = '0;
            run_cnt_d    = '0;
            write_d      = 1'b0;
            program_in_d = '0;
            start_d      = 1'b0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            remain_q     <= '0;
            run_cnt_q    <= '0;
            write_q      <= 1'b0;
            program_in_q <= '0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            remain_q     <= remain_d;
            run_cnt_q    <= run_cnt_d;
            write_q      <= write_d;
            program_in_q <= program_in_d;
            start_q      <= start_d;
            done_q       <= done_d;
        end
    end

    // Storage needs no reset: only slots written since the last clear are read.
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            mem_q[wr_ptr_q] <= in_word;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//   Scoreboard bench: the driver keeps a program-level model (word queue plus a
//   busy-cycle budget) and, when a program closes, pushes the expected write
//   words, the run and the done pulse into exp_q. A negedge monitor pops and
//   compares whatever the loader presents.
// -----------------------------------------------------------------------------
module tb_program_loader;

    localparam int W   = 23;
    localparam int D   = 16;
    localparam int RC  = 10;

    localparam int K_WR   = 0;
    localparam int K_RUN  = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int          kind;
        logic [W-1:0] data;
    } item_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_word = '0;
    logic          in_last = 1'b0;
    logic          abort = 1'b0;
    logic          write;
    logic [W-1:0]  program_in;
    logic          start;
    logic          busy;
    logic          done;
    logic [4:0]    count;

    program_loader #(.WORD_W(W), .DEPTH(D), .RUN_CYCLES(RC)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .in_last    (in_last),
        .abort      (abort),
        .write      (write),
        .program_in (program_in),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    item_t        exp_q[$];
    logic [W-1:0] prog_q[$];
    int           busy_left = 0;
    bit           started = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    bit prev_write = 1'b0;
    bit prev_start = 1'b0;
    int run_len    = 0;

    always @(negedge clk) begin
        item_t it;
        if (started) begin
            if (write === 1'b1 && start === 1'b1) chk("write_start_overlap", 1, 0);
            if (write !== 1'b1) chk("prog_zero_idle", 32'(program_in), 0);
            if (write === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_write", 32'(program_in), 32'hFFFF_FFFF);
                else begin
                    it = exp_q.pop_front();
                    chk("wr_kind", it.kind, K_WR);
                    chk("wr_data", 32'(program_in), 32'(it.data));
                end
            end
            if (start === 1'b1 && !prev_start) begin
                if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
                else begin
                    it = exp_q.pop_front();
                    chk("run_kind", it.kind, K_RUN);
                end
                chk("start_after_write", 32'(prev_write), 1);
                run_len = 0;
            end
            if (start === 1'b1) run_len++;
            if (done === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    it = exp_q.pop_front();
                    chk("done_kind", it.kind, K_DONE);
                end
                chk("run_len", run_len, RC);
                chk("done_after_start", 32'(prev_start), 1);
            end
            prev_write = (write === 1'b1);
            prev_start = (start === 1'b1);
        end
    end

    // ---------------- driver + model ----------------
    task automatic flush_model();
        prog_q.delete();
        exp_q.delete();
        busy_left = 0;
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] w, input logic l, input logic ab);
        bit mready;
        bit acc;
        in_valid = v;
        in_word  = w;
        in_last  = l;
        abort    = ab;
        #1;
        mready = (busy_left == 0) && (prog_q.size() < D);
        chk("in_ready", 32'(in_ready), 32'(mready));
        chk("busy", 32'(busy), 32'(busy_left != 0));
        if (busy_left == 0) chk("count", 32'(count), prog_q.size());
        acc = v && mready && !ab;
        @(posedge clk);
        #1;
        if (ab) begin
            flush_model();
        end else if (acc) begin
            prog_q.push_back(w);
            if (l || prog_q.size() == D) begin
                int n;
                n = prog_q.size();
                foreach (prog_q[i]) exp_q.push_back('{K_WR, prog_q[i]});
                exp_q.push_back('{K_RUN, '0});
                exp_q.push_back('{K_DONE, '0});
                busy_left = n + RC + 1;
                prog_q.delete();
            end
        end else if (busy_left > 0) begin
            busy_left--;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_write"}, 32'(write), 0);
        chk({tag, "_prog"}, 32'(program_in), 0);
        chk({tag, "_start"}, 32'(start), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_ready"}, 32'(in_ready), 1);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        abort    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        flush_model();
    endtask

    initial begin
        @(posedge clk);
        do_reset();
        started = 1'b1;
        check_reset_values("reset");

        // single zero word
        cyc(1'b1, 23'h000000, 1'b1, 1'b0);
        idle(RC + 4);
        chk("single_count", 32'(count), 0);

        // three words, last on third
        cyc(1'b1, 23'h000001, 1'b0, 1'b0);
        cyc(1'b1, 23'h2AAAAA, 1'b0, 1'b0);
        cyc(1'b1, 23'h7FFFFF, 1'b1, 1'b0);
        idle(RC + 6);

        // overflow: 16 words without in_last, valid kept high into LOAD/RUN
        for (int i = 0; i < D; i++) cyc(1'b1, W'(32'h100 + i), 1'b0, 1'b0);
        for (int i = 0; i < D + RC + 1; i++) cyc(1'b1, W'(32'h555 + i), 1'b1, 1'b0);
        // next accepted word is word 0 of a fresh program
        idle(3);

        // abort during the 5th start cycle
        cyc(1'b1, 23'h0ABCDE, 1'b1, 1'b0);
        idle(5);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("abort_start", 32'(start), 0);
        chk("abort_ready", 32'(in_ready), 1);
        chk("abort_count", 32'(count), 0);
        idle(RC + 4);

        // reset mid-LOAD after 2 of 4 strobes
        for (int i = 0; i < 4; i++) cyc(1'b1, W'(32'h3000 + i), (i == 3), 1'b0);
        idle(1);
        do_reset();
        check_reset_values("midload");
        idle(4);
        cyc(1'b1, 23'h123456, 1'b1, 1'b0);
        idle(RC + 4);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 99) == 0));
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        idle(D + RC + 4);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
